// File: rtl/csr_exec_unit.sv
// Zicsr execute unit: reads the old CSR value with MEM/WB forwarding,
// computes the new value and carries the write through MEM and WB.
module csr_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit RO_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [2:0]      ex_funct3,
  input  logic [11:0]     ex_csr_addr,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [4:0]      ex_rs1_field,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] ex_rd_data,
  output logic            ex_illegal,
  output logic            csr_write_en,
  output logic [11:0]     csr_wb_addr,
  output logic [XLEN-1:0] csr_wb_data
);

  logic            r_mem_wen;
  logic [11:0]     r_mem_addr;
  logic [XLEN-1:0] r_mem_data;
  logic            r_wb_wen;
  logic [11:0]     r_wb_addr;
  logic [XLEN-1:0] r_wb_data;

  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_new;
  logic            w_wr;
  logic            w_bad_op;
  logic            w_ro;
  logic            w_illegal;
  logic            w_accept;

  assign csr_raddr = ex_csr_addr;

  // WB data is forwarded because the file commits only at negedge
  always_comb begin
    w_old = csr_rdata;
    if (r_mem_wen && (r_mem_addr == ex_csr_addr))
      w_old = r_mem_data;
    else if (r_wb_wen && (r_wb_addr == ex_csr_addr))
      w_old = r_wb_data;
  end

  assign w_src = ex_funct3[2]
               ? {{(XLEN-5){1'b0}}, ex_rs1_field}
               : ex_rs1_data;

  always_comb begin
    w_new = w_src;
    case (ex_funct3[1:0])
      2'b10:   w_new = w_old | w_src;
      2'b11:   w_new = w_old & ~w_src;
      default: w_new = w_src;
    endcase
  end

  assign w_wr      = (ex_funct3[1:0] == 2'b01)
                   || (ex_rs1_field != 5'd0);
  assign w_bad_op  = (ex_funct3[1:0] == 2'b00);
  assign w_ro      = RO_CHECK && (&ex_csr_addr[11:10]) && w_wr;
  assign w_illegal = w_bad_op || w_ro;
  assign w_accept  = ex_valid && !w_illegal
                   && !flush && !stall;

  assign ex_rd_data = w_old;
  assign ex_illegal = ex_valid && w_illegal;

  // Bubbles clear only the enable; addr/data keep their last values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_wen  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_wb_wen   <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      if (w_accept) begin
        r_mem_wen  <= w_wr;
        r_mem_addr <= ex_csr_addr;
        r_mem_data <= w_new;
      end else begin
        r_mem_wen  <= 1'b0;
      end
      if (flush) begin
        r_wb_wen  <= 1'b0;
      end else begin
        r_wb_wen  <= r_mem_wen;
        r_wb_addr <= r_mem_addr;
        r_wb_data <= r_mem_data;
      end
    end
  end

  assign csr_write_en = r_wb_wen;
  assign csr_wb_addr  = r_wb_addr;
  assign csr_wb_data  = r_wb_data;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: directed vector table, hand sequences
// and randomized ops against a pending-write queue model.
module tb_csr_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [11:0] ex_csr_addr = 12'd0;
  logic [31:0] ex_rs1_data = 32'd0;
  logic [4:0]  ex_rs1_field = 5'd0;
  logic [31:0] csr_rdata;
  logic [11:0] csr_raddr;
  logic [31:0] ex_rd_data;
  logic        ex_illegal;
  logic        csr_write_en;
  logic [11:0] csr_wb_addr;
  logic [31:0] csr_wb_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] csr_file [4096];
  logic [31:0] ref_csr  [4096];

  csr_exec_unit #(.XLEN(32), .RO_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_funct3(ex_funct3),
    .ex_csr_addr(ex_csr_addr), .ex_rs1_data(ex_rs1_data),
    .ex_rs1_field(ex_rs1_field), .csr_rdata(csr_rdata),
    .csr_raddr(csr_raddr), .ex_rd_data(ex_rd_data),
    .ex_illegal(ex_illegal), .csr_write_en(csr_write_en),
    .csr_wb_addr(csr_wb_addr), .csr_wb_data(csr_wb_data)
  );

  always #5 clk = ~clk;

  always_comb csr_rdata = csr_file[csr_raddr];

  always @(negedge clk)
    if (csr_write_en) csr_file[csr_wb_addr] <= csr_wb_data;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic [4:0] fld);
    ex_valid = v; ex_funct3 = f3; ex_csr_addr = a;
    ex_rs1_data = d; ex_rs1_field = fld;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] a;
    logic [31:0] rs1;
    logic [4:0]  fld;
    logic [31:0] init;
    logic [31:0] rd;
    logic        ill;
    logic        wen;
    logic [31:0] wd;
  } vec_t;

  vec_t vt [15];

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    int          st;
  } pend_t;

  pend_t q [$];

  function automatic logic [31:0] m_old(input logic [11:0] a);
    logic [31:0] v;
    v = ref_csr[a];
    foreach (q[i]) if (q[i].a == a) v = q[i].d;
    return v;
  endfunction

  logic [11:0] addrs [6] = '{12'h300, 12'h340, 12'hC00,
                             12'hFFF, 12'h000, 12'h305};

  initial begin
    logic [31:0] src, old, nv, wd;
    logic        wr, ill, en;
    logic [11:0] wa;
    pend_t       nq [$];

    for (int i = 0; i < 4096; i++) begin
      csr_file[i] = 32'd0;
      ref_csr[i]  = 32'd0;
    end

    vt[0]  = '{3'b010, 12'h300, 32'h0F, 5'd5, 32'hF0, 32'hF0, 1'b0, 1'b1, 32'hFF};
    vt[1]  = '{3'b001, 12'h305, 32'hDEADBEEF, 5'd3, 32'h1234, 32'h1234, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[2]  = '{3'b011, 12'h340, 32'h0F, 5'd1, 32'hFF, 32'hFF, 1'b0, 1'b1, 32'hF0};
    vt[3]  = '{3'b101, 12'h341, 32'hFFFFFFFF, 5'h1F, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1F};
    vt[4]  = '{3'b101, 12'h341, 32'hFFFFFFFF, 5'd0, 32'h1F, 32'h1F, 1'b0, 1'b1, 32'h0};
    vt[5]  = '{3'b110, 12'h300, 32'hFFFFFFFF, 5'd3, 32'h100, 32'h100, 1'b0, 1'b1, 32'h103};
    vt[6]  = '{3'b111, 12'h300, 32'h0, 5'h0F, 32'hFF, 32'hFF, 1'b0, 1'b1, 32'hF0};
    vt[7]  = '{3'b010, 12'hC00, 32'h5, 5'd0, 32'hABCD, 32'hABCD, 1'b0, 1'b0, 32'h0};
    vt[8]  = '{3'b001, 12'hC00, 32'h5, 5'd2, 32'hABCD, 32'hABCD, 1'b1, 1'b0, 32'h0};
    vt[9]  = '{3'b100, 12'h300, 32'h0, 5'd1, 32'h5, 32'h5, 1'b1, 1'b0, 32'h0};
    vt[10] = '{3'b000, 12'h300, 32'h0, 5'd0, 32'h7, 32'h7, 1'b1, 1'b0, 32'h0};
    vt[11] = '{3'b001, 12'h000, 32'h55, 5'd1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55};
    vt[12] = '{3'b110, 12'hFFF, 32'h0, 5'd0, 32'h77, 32'h77, 1'b0, 1'b0, 32'h0};
    vt[13] = '{3'b111, 12'hFFF, 32'h0, 5'd1, 32'h77, 32'h77, 1'b1, 1'b0, 32'h0};
    vt[14] = '{3'b010, 12'h300, 32'hFF, 5'd0, 32'h9, 32'h9, 1'b0, 1'b0, 32'h0};

    #2;
    chk("reset_wen", {31'd0, csr_write_en}, 32'd0);
    chk("reset_addr", {20'd0, csr_wb_addr}, 32'd0);
    chk("reset_data", csr_wb_data, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    foreach (vt[i]) begin
      csr_file[vt[i].a] = vt[i].init;
      drive(1'b1, vt[i].f3, vt[i].a, vt[i].rs1, vt[i].fld);
      #1;
      chk($sformatf("vec%0d_rd", i), ex_rd_data, vt[i].rd);
      chk($sformatf("vec%0d_ill", i), {31'd0, ex_illegal}, {31'd0, vt[i].ill});
      tick();
      drive(1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
      chk($sformatf("vec%0d_wen_n1", i), {31'd0, csr_write_en}, 32'd0);
      tick();
      chk($sformatf("vec%0d_wen", i), {31'd0, csr_write_en}, {31'd0, vt[i].wen});
      if (vt[i].wen) begin
        chk($sformatf("vec%0d_waddr", i), {20'd0, csr_wb_addr}, {20'd0, vt[i].a});
        chk($sformatf("vec%0d_wdata", i), csr_wb_data, vt[i].wd);
      end
      tick();
      chk($sformatf("vec%0d_file", i), csr_file[vt[i].a],
          vt[i].wen ? vt[i].wd : vt[i].init);
    end

    // back-to-back ops on 0x340: MEM forwarding
    csr_file[12'h340] = 32'h55;
    drive(1'b1, 3'b101, 12'h340, 32'h0, 5'd7);
    #1 chk("b2b_rd1", ex_rd_data, 32'h55);
    tick();
    drive(1'b1, 3'b011, 12'h340, 32'h3, 5'd2);
    #1 chk("b2b_rd2", ex_rd_data, 32'h7);
    tick();
    drive(1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    chk("b2b_w1", csr_wb_data, 32'h7);
    chk("b2b_a1", {20'd0, csr_wb_addr}, 32'h340);
    tick();
    chk("b2b_en2", {31'd0, csr_write_en}, 32'd1);
    chk("b2b_w2", csr_wb_data, 32'h4);
    tick();
    chk("b2b_file", csr_file[12'h340], 32'h4);

    // WB forwarding: reader two cycles behind writer
    drive(1'b1, 3'b001, 12'h305, 32'hA5A5, 5'd1);
    tick();
    drive(1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    tick();
    drive(1'b1, 3'b010, 12'h305, 32'h0F00, 5'd1);
    #1 chk("wbfwd_rd", ex_rd_data, 32'hA5A5);
    tick();
    drive(1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    tick();
    chk("wbfwd_en", {31'd0, csr_write_en}, 32'd1);
    chk("wbfwd_data", csr_wb_data, 32'hAFA5);
    tick();

    // flush: WB write retires, MEM and EX writes are killed
    csr_file[12'h300] = 32'h0;
    csr_file[12'h305] = 32'h0;
    csr_file[12'h341] = 32'h0;
    drive(1'b1, 3'b001, 12'h300, 32'h11, 5'd1);
    tick();
    drive(1'b1, 3'b001, 12'h305, 32'h22, 5'd1);
    tick();
    drive(1'b1, 3'b001, 12'h341, 32'h33, 5'd1);
    flush = 1'b1;
    #1 chk("flush_wb_en", {31'd0, csr_write_en}, 32'd1);
    chk("flush_wb_data", csr_wb_data, 32'h11);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    chk("flush_en1", {31'd0, csr_write_en}, 32'd0);
    tick();
    chk("flush_en2", {31'd0, csr_write_en}, 32'd0);
    tick();
    chk("flush_f300", csr_file[12'h300], 32'h11);
    chk("flush_f305", csr_file[12'h305], 32'h0);
    chk("flush_f341", csr_file[12'h341], 32'h0);

    // stall holds the op; write lands two cycles after release
    drive(1'b1, 3'b001, 12'h340, 32'h99, 5'd1);
    stall = 1'b1;
    tick();
    chk("stall_en0", {31'd0, csr_write_en}, 32'd0);
    tick();
    chk("stall_en1", {31'd0, csr_write_en}, 32'd0);
    stall = 1'b0;
    tick();
    drive(1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    chk("stall_en2", {31'd0, csr_write_en}, 32'd0);
    tick();
    chk("stall_en3", {31'd0, csr_write_en}, 32'd1);
    chk("stall_data", csr_wb_data, 32'h99);
    tick();

    // async reset with op in WB
    csr_file[12'h305] = 32'h1;
    drive(1'b1, 3'b001, 12'h305, 32'h77, 5'd1);
    tick();
    drive(1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    tick();
    chk("rst_pre_en", {31'd0, csr_write_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_en", {31'd0, csr_write_en}, 32'd0);
    chk("rst_addr", {20'd0, csr_wb_addr}, 32'd0);
    chk("rst_data", csr_wb_data, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_lost", csr_file[12'h305], 32'h1);
    tick();

    // randomized phase against the queue model
    for (int i = 0; i < 4096; i++) ref_csr[i] = csr_file[i];
    q.delete();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)),
            addrs[$urandom_range(0, 5)], $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      #1;
      src = ex_funct3[2] ? {27'd0, ex_rs1_field} : ex_rs1_data;
      old = m_old(ex_csr_addr);
      if (ex_funct3[1:0] == 2'b01)      nv = src;
      else if (ex_funct3[1:0] == 2'b10) nv = old | src;
      else                              nv = old & ~src;
      wr  = (ex_funct3[1:0] == 2'b01) || (ex_rs1_field != 5'd0);
      ill = (ex_funct3[1:0] == 2'b00)
         || ((ex_csr_addr[11:10] == 2'b11) && wr);
      chk("rnd_raddr", {20'd0, csr_raddr}, {20'd0, ex_csr_addr});
      chk("rnd_rd", ex_rd_data, old);
      chk("rnd_ill", {31'd0, ex_illegal}, {31'd0, ex_valid && ill});
      en = 1'b0; wa = 12'd0; wd = 32'd0;
      foreach (q[k]) if (q[k].st == 2) begin
        en = 1'b1; wa = q[k].a; wd = q[k].d;
      end
      chk("rnd_wen", {31'd0, csr_write_en}, {31'd0, en});
      if (en) begin
        chk("rnd_waddr", {20'd0, csr_wb_addr}, {20'd0, wa});
        chk("rnd_wdata", csr_wb_data, wd);
      end
      nq.delete();
      foreach (q[k]) begin
        if (q[k].st == 2) ref_csr[q[k].a] = q[k].d;
        else if (!flush) nq.push_back('{q[k].a, q[k].d, 2});
      end
      if (ex_valid && !ill && wr && !flush && !stall)
        nq.push_back('{ex_csr_addr, nv, 1});
      q = nq;
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 3'd0, 12'd0, 32'd0, 5'd0);
    tick();
    tick();
    tick();
    foreach (addrs[k])
      chk("rnd_final", csr_file[addrs[k]], ref_csr[addrs[k]]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
